// File: rtl/viterbi_ctrl.sv
`default_nettype none
// ============================================================================
// Module : viterbi_ctrl
// Frame sequencer for a 4-state rate-1/2 hard-decision Viterbi decoder.
// Rev    : 1.0
// ============================================================================
module viterbi_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sym_valid,
  input  logic [1:0]           i_sym,
  output logic                 o_sym_ready,
  output logic [1:0]           o_bm_sym,
  output logic                 o_en_add,
  output logic                 o_acs_rst_n,
  input  logic [1:0]           i_prv_st_00,
  input  logic [1:0]           i_prv_st_10,
  input  logic [1:0]           i_prv_st_01,
  input  logic [1:0]           i_prv_st_11,
  input  logic [1:0]           i_select_node,
  output logic [FRAME_LEN-1:0] o_dec_bits,
  output logic                 o_dec_valid,
  input  logic                 i_dec_ready,
  output logic                 o_busy
);

  localparam int c_CNT_W = $clog2(FRAME_LEN + 1);
  localparam int c_IDX_W = $clog2(FRAME_LEN);
  localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LEN     = c_CNT_W'(FRAME_LEN);
  localparam logic [c_CNT_W-1:0] c_LEN_M1  = c_CNT_W'(FRAME_LEN - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_M1  = c_IDX_W'(FRAME_LEN - 1);
  localparam logic [c_SET_W-1:0] c_SET_ONE = c_SET_W'(1);
  localparam logic [c_SET_W-1:0] c_SET_M1  = c_SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_CLR    = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_TRACE  = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_bm_sym;
  logic                 r_en_add;
  logic                 r_cap_en;
  logic [c_CNT_W-1:0]   r_acc_cnt;
  logic [c_CNT_W-1:0]   r_cap_cnt;
  logic [c_SET_W-1:0]   r_set_cnt;
  logic [c_IDX_W-1:0]   r_tr_idx;
  logic [1:0]           r_tb_state;
  logic [FRAME_LEN-1:0] r_dec;
  logic [1:0]           r_surv [FRAME_LEN][4];

  logic w_accept;
  logic w_last_acc;
  logic w_cap_done;
  logic w_set_last;
  logic w_tr_last;
  logic w_sym_ready;
  logic w_acs_rst_n;
  logic w_dec_valid;
  logic w_busy;

  assign w_accept   = i_sym_valid && (r_state == ST_RUN);
  assign w_last_acc = w_accept && (r_acc_cnt == c_LEN_M1);
  // Leave DRAIN on the edge of the final capture so SETTLE starts right after it.
  assign w_cap_done = (r_cap_cnt == c_LEN) || (r_cap_en && (r_cap_cnt == c_LEN_M1));
  assign w_set_last = (r_set_cnt == c_SET_M1);
  assign w_tr_last  = (r_tr_idx == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_sym_ready = 1'b0;
    w_acs_rst_n = 1'b1;
    w_dec_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_CLR: begin
        w_acs_rst_n = 1'b0;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_sym_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_last_acc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_cap_done) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_set_last) w_state_nxt = ST_TRACE;
      end
      ST_TRACE: begin
        if (w_tr_last) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_dec_valid = 1'b1;
        if (i_dec_ready) w_state_nxt = ST_CLR;
      end
      default: begin
        w_state_nxt = ST_CLR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_CLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bm_sym   <= 2'b00;
      r_en_add   <= 1'b0;
      r_cap_en   <= 1'b0;
      r_acc_cnt  <= '0;
      r_cap_cnt  <= '0;
      r_set_cnt  <= '0;
      r_tr_idx   <= '0;
      r_tb_state <= 2'b00;
      r_dec      <= '0;
      for (int s = 0; s < FRAME_LEN; s++) begin
        for (int n = 0; n < 4; n++) begin
          r_surv[s][n] <= 2'b00;
        end
      end
    end else begin
      r_en_add <= w_accept;
      r_cap_en <= r_en_add;
      if (w_accept) begin
        r_bm_sym  <= i_sym;
        r_acc_cnt <= r_acc_cnt + c_CNT_ONE;
      end

      if (r_state == ST_CLR) begin
        r_acc_cnt <= '0;
        r_cap_cnt <= '0;
      end else if (r_cap_en && (r_cap_cnt < c_LEN)) begin
        r_surv[r_cap_cnt[c_IDX_W-1:0]][2'b00] <= i_prv_st_00;
        r_surv[r_cap_cnt[c_IDX_W-1:0]][2'b01] <= i_prv_st_01;
        r_surv[r_cap_cnt[c_IDX_W-1:0]][2'b10] <= i_prv_st_10;
        r_surv[r_cap_cnt[c_IDX_W-1:0]][2'b11] <= i_prv_st_11;
        r_cap_cnt <= r_cap_cnt + c_CNT_ONE;
      end

      if (r_state == ST_SETTLE) begin
        r_set_cnt <= r_set_cnt + c_SET_ONE;
        if (w_set_last) begin
          r_tb_state <= i_select_node;
          r_tr_idx   <= c_IDX_M1;
        end
      end else begin
        r_set_cnt <= '0;
      end

      // State MSB is the decoded bit: only input 1 leads into states 10/11.
      if (r_state == ST_TRACE) begin
        r_dec[r_tr_idx] <= r_tb_state[1];
        r_tb_state      <= r_surv[r_tr_idx][r_tb_state];
        if (!w_tr_last) r_tr_idx <= r_tr_idx - c_IDX_ONE;
      end
    end
  end

  assign o_sym_ready = w_sym_ready;
  assign o_bm_sym    = r_bm_sym;
  assign o_en_add    = r_en_add;
  assign o_acs_rst_n = w_acs_rst_n;
  assign o_dec_bits  = r_dec;
  assign o_dec_valid = w_dec_valid;
  assign o_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_viterbi_ctrl
// Directed self-checking bench for viterbi_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_viterbi_ctrl;

  localparam int FL = 8;
  localparam int ST = 2;

  logic          clk;
  logic          rst;
  logic          i_sym_valid;
  logic [1:0]    i_sym;
  logic          o_sym_ready;
  logic [1:0]    o_bm_sym;
  logic          o_en_add;
  logic          o_acs_rst_n;
  logic [1:0]    i_prv_st_00, i_prv_st_10, i_prv_st_01, i_prv_st_11;
  logic [1:0]    i_select_node;
  logic [FL-1:0] o_dec_bits;
  logic          o_dec_valid;
  logic          i_dec_ready;
  logic          o_busy;

  int n_chk = 0;
  int n_err = 0;

  int f_acc, f_en, f_en_err, f_bm_err, f_lat;
  bit f_to, f_clr_ok, f_run_ok;

  logic [1:0] syms [FL] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [14:0] RST_VEC = {1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

  viterbi_ctrl #(.FRAME_LEN(FL), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst),
    .i_sym_valid(i_sym_valid), .i_sym(i_sym), .o_sym_ready(o_sym_ready),
    .o_bm_sym(o_bm_sym), .o_en_add(o_en_add), .o_acs_rst_n(o_acs_rst_n),
    .i_prv_st_00(i_prv_st_00), .i_prv_st_10(i_prv_st_10),
    .i_prv_st_01(i_prv_st_01), .i_prv_st_11(i_prv_st_11),
    .i_select_node(i_select_node), .o_dec_bits(o_dec_bits),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern A: 00<-00 10<-00 01<-10 11<-11.  Pattern B: 00<-01 01<-11 10<-00 11<-10.
  task automatic set_surv(input bit b);
    if (!b) begin
      i_prv_st_00 = 2'b00; i_prv_st_10 = 2'b00; i_prv_st_01 = 2'b10; i_prv_st_11 = 2'b11;
    end else begin
      i_prv_st_00 = 2'b01; i_prv_st_10 = 2'b00; i_prv_st_01 = 2'b11; i_prv_st_11 = 2'b10;
    end
  endtask

  // Streams one frame from a RUN cycle and stops at the first OUT cycle (or after
  // the abort reset edge). Survivors follow a one-cycle-latency ACS when vary=1.
  task automatic send_frame(input logic [1:0] sel, input bit gap, input bit vary,
                            input bit rdy, input int abort_j);
    int last, cstep;
    bit ad1, ad2, acc_now;
    logic [1:0] lsym;
    last = -1; cstep = 0; ad1 = 0; ad2 = 0; lsym = 2'b00;
    f_acc = 0; f_en = 0; f_en_err = 0; f_bm_err = 0; f_lat = -1; f_to = 1;
    i_dec_ready = rdy;
    set_surv(vary);
    for (int j = 0; j < 300; j++) begin
      if (o_en_add === 1'b1) f_en++;
      if (o_en_add !== ad1) f_en_err++;
      if (ad1 && (o_bm_sym !== lsym)) f_bm_err++;
      if (o_dec_valid === 1'b1) begin
        f_lat = j - last; f_to = 0;
        break;
      end
      if (abort_j > 0 && f_acc == FL && j == last + abort_j) begin
        rst = 1'b0;
        tick();
        f_to = 0;
        break;
      end
      i_sym_valid   = (f_acc < FL) ? (!gap || (j % 2 == 0)) : 1'b1;
      i_sym         = syms[f_acc % FL];
      i_select_node = (f_acc == FL && j == last + 2 + ST) ? sel : ~sel;
      if (ad2) begin
        if (vary) set_surv(cstep[0]);
        cstep++;
      end
      acc_now = i_sym_valid && (o_sym_ready === 1'b1);
      if (acc_now) begin
        f_acc++; last = j; lsym = i_sym;
      end
      tick();
      ad2 = ad1; ad1 = acc_now;
    end
  endtask

  task automatic release_out();
    i_sym_valid = 1'b0;
    i_dec_ready = 1'b1;
    tick();
    f_clr_ok = (o_dec_valid === 1'b0) && (o_acs_rst_n === 1'b0) && (o_sym_ready === 1'b0);
    i_dec_ready = 1'b0;
    tick();
    f_run_ok = (o_sym_ready === 1'b1) && (o_acs_rst_n === 1'b1) && (o_busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; i_sym_valid = 1'b1; i_sym = 2'b11; i_dec_ready = 1'b1;
    i_select_node = 2'b11; set_surv(1'b0);
    repeat (3) tick();
    n_chk++;
    if ({o_sym_ready, o_bm_sym, o_en_add, o_acs_rst_n, o_dec_bits, o_dec_valid, o_busy} !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_values got=%h exp=%h",
               {o_sym_ready, o_bm_sym, o_en_add, o_acs_rst_n, o_dec_bits, o_dec_valid, o_busy}, RST_VEC);
    end
    rst = 1'b1; i_sym_valid = 1'b0; i_dec_ready = 1'b0;
    n_chk++;
    if ({o_acs_rst_n, o_sym_ready} !== 2'b00) begin
      n_err++; $display("FAIL clr_cycle acs_rst_n,ready got=%b exp=00", {o_acs_rst_n, o_sym_ready});
    end
    tick();
    n_chk++;
    if ({o_acs_rst_n, o_sym_ready, o_busy} !== 3'b110) begin
      n_err++; $display("FAIL run_after_clr acs,ready,busy got=%b exp=110", {o_acs_rst_n, o_sym_ready, o_busy});
    end
  endtask

  task automatic test_back_to_back();
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 0);
    n_chk++; if (f_to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got=%0d exp=0", f_to); end
    n_chk++; if (f_acc != FL) begin n_err++; $display("FAIL b2b_accepts got=%0d exp=%0d", f_acc, FL); end
    n_chk++; if (f_en != FL || f_en_err != 0) begin n_err++; $display("FAIL b2b_en_add pulses=%0d bad=%0d exp=8/0", f_en, f_en_err); end
    n_chk++; if (f_bm_err != 0) begin n_err++; $display("FAIL b2b_bm_sym bad=%0d exp=0", f_bm_err); end
    n_chk++; if (f_lat != 13) begin n_err++; $display("FAIL b2b_latency got=%0d exp=13", f_lat); end
    n_chk++; if (o_dec_bits !== 8'hFF) begin n_err++; $display("FAIL b2b_bits got=%h exp=ff", o_dec_bits); end
    n_chk++; if ({o_sym_ready, o_busy} !== 2'b01) begin n_err++; $display("FAIL b2b_out_flags got=%b exp=01", {o_sym_ready, o_busy}); end
    release_out();
    n_chk++; if (!f_clr_ok) begin n_err++; $display("FAIL b2b_clr_after_out got=0 exp=1"); end
    n_chk++; if (!f_run_ok) begin n_err++; $display("FAIL b2b_run_after_clr got=0 exp=1"); end
  endtask

  task automatic test_traceback();
    logic [1:0] sels [3] = '{2'b01, 2'b00, 2'b10};
    logic [7:0] exps [3] = '{8'h40, 8'h00, 8'h80};
    for (int k = 0; k < 3; k++) begin
      send_frame(sels[k], 1'b0, 1'b0, 1'b0, 0);
      n_chk++;
      if (f_to !== 1'b0 || o_dec_bits !== exps[k]) begin
        n_err++; $display("FAIL traceback sel=%b got=%h exp=%h timeout=%0d", sels[k], o_dec_bits, exps[k], f_to);
      end
      release_out();
      n_chk++; if (!(f_clr_ok && f_run_ok)) begin n_err++; $display("FAIL traceback_release sel=%b got=0 exp=1", sels[k]); end
    end
  endtask

  task automatic test_valid_gaps();
    send_frame(2'b11, 1'b1, 1'b0, 1'b1, 0);
    n_chk++; if (f_to !== 1'b0) begin n_err++; $display("FAIL gaps_timeout got=%0d exp=0", f_to); end
    n_chk++; if (f_en != FL || f_en_err != 0) begin n_err++; $display("FAIL gaps_en_add pulses=%0d bad=%0d exp=8/0", f_en, f_en_err); end
    n_chk++; if (f_bm_err != 0) begin n_err++; $display("FAIL gaps_bm_sym bad=%0d exp=0", f_bm_err); end
    n_chk++; if (f_lat != 13) begin n_err++; $display("FAIL gaps_latency got=%0d exp=13", f_lat); end
    n_chk++; if (o_dec_bits !== 8'hFF) begin n_err++; $display("FAIL gaps_bits got=%h exp=ff", o_dec_bits); end
    release_out();
    n_chk++; if (!(f_clr_ok && f_run_ok)) begin n_err++; $display("FAIL gaps_release got=0 exp=1"); end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 0);
    n_chk++; if (f_to !== 1'b0) begin n_err++; $display("FAIL bp_timeout got=%0d exp=0", f_to); end
    i_sym_valid = 1'b1; i_dec_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_dec_valid !== 1'b1 || o_dec_bits !== 8'hFF || o_sym_ready !== 1'b0 || o_en_add !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", bad); end
    release_out();
    n_chk++; if (!(f_clr_ok && f_run_ok)) begin n_err++; $display("FAIL bp_release got=0 exp=1"); end
    send_frame(2'b01, 1'b0, 1'b0, 1'b0, 0);
    n_chk++; if (f_to !== 1'b0 || o_dec_bits !== 8'h40) begin n_err++; $display("FAIL bp_next_frame got=%h exp=40", o_dec_bits); end
    release_out();
  endtask

  task automatic test_mid_reset();
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 7);
    n_chk++;
    if ({o_sym_ready, o_bm_sym, o_en_add, o_acs_rst_n, o_dec_bits, o_dec_valid, o_busy} !== RST_VEC) begin
      n_err++;
      $display("FAIL midreset_values got=%h exp=%h",
               {o_sym_ready, o_bm_sym, o_en_add, o_acs_rst_n, o_dec_bits, o_dec_valid, o_busy}, RST_VEC);
    end
    rst = 1'b1; i_sym_valid = 1'b0;
    n_chk++; if (o_acs_rst_n !== 1'b0) begin n_err++; $display("FAIL midreset_clr got=%b exp=0", o_acs_rst_n); end
    tick();
    n_chk++; if (o_sym_ready !== 1'b1) begin n_err++; $display("FAIL midreset_run got=%b exp=1", o_sym_ready); end
    send_frame(2'b11, 1'b0, 1'b1, 1'b0, 0);
    n_chk++; if (f_to !== 1'b0 || f_lat != 13) begin n_err++; $display("FAIL midreset_latency got=%0d exp=13", f_lat); end
    n_chk++; if (o_dec_bits !== 8'hC8) begin n_err++; $display("FAIL midreset_bits got=%h exp=c8", o_dec_bits); end
    release_out();
    n_chk++; if (!(f_clr_ok && f_run_ok)) begin n_err++; $display("FAIL midreset_release got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_traceback();
    test_valid_gaps();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame sequencer for the 4-state, rate-1/2 hard-decision Viterbi decoder. It accepts received 2-bit symbols over a valid/ready handshake and presents each one to the branch-metric unit. It pulses the ACS enable once per accepted symbol, clears the ACS path metrics at every frame start, and stores the four survivor pointers per trellis step. At frame end it traces back from the ACS-selected final state and emits the decoded frame as one word over a valid/ready handshake.

## Interface
Parameters:
- FRAME_LEN, 8: symbols per frame, and decoded bits per output word (≥2).
- SETTLE, 2: cycles between the last survivor capture and the sampling of i_select_node (≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- i_sym_valid  in  1  a received symbol is offered.
- i_sym  in  2  received symbol bits.
- o_sym_ready  out  1  the controller can accept a symbol this cycle.
- o_bm_sym  out  2  registered symbol, driven to the branch-metric unit.
- o_en_add  out  1  ACS enable; one-cycle pulse per accepted symbol.
- o_acs_rst_n  out  1  active-low clear of the ACS metrics and counters.
- i_prv_st_00, i_prv_st_10, i_prv_st_01, i_prv_st_11  in  2 each  survivor predecessor for each state.
- i_select_node  in  2  final minimum-metric state.
- o_dec_bits  out  FRAME_LEN  decoded frame; bit t belongs to symbol t (t=0 is the first symbol).
- o_dec_valid  out  1  o_dec_bits is valid.
- i_dec_ready  in  1  the consumer accepts the word.
- o_busy  out  1  high in every state except RUN.

## Operation
States and transitions:
- CLR: o_acs_rst_n=0 for exactly 1 cycle, then go to RUN.
- RUN: o_sym_ready=1. A symbol is accepted when i_sym_valid && o_sym_ready; it increments acc_cnt. When the FRAME_LEN-th symbol is accepted, go to DRAIN.
- DRAIN: o_sym_ready=0. Stay until cap_cnt==FRAME_LEN, then go to SETTLE.
- SETTLE: count SETTLE cycles. On the last cycle, latch i_select_node into tb_state, then go to TRACE.
- TRACE: FRAME_LEN cycles, with t running from FRAME_LEN-1 down to 0. Each cycle: dec[t] <= tb_state[1]; tb_state <= surv[t][tb_state]. Then go to OUT.
- OUT: o_dec_valid=1 with o_dec_bits held stable until i_dec_ready=1. On that transfer, go to CLR.

Accept and capture path:
- On each accept, o_bm_sym <= i_sym and o_en_add <= 1 on the next cycle; otherwise o_en_add <= 0 and o_bm_sym holds.
- o_en_add is delayed by one cycle to form cap_en. When cap_en=1, the survivor memory surv[cap_cnt] stores all four i_prv_st_* indexed by state code (00, 01, 10, 11), and cap_cnt increments.

Storage:
- Survivor memory is FRAME_LEN × 4 × 2 bits of registers.
- Counter widths are $clog2(FRAME_LEN+1).
- The decoded bit is the MSB of the state, because the trellis enters states 10 and 11 only on input 1.

Boundary conditions:
- i_sym_valid gaps in RUN are allowed: o_en_add stays low for those cycles and capture skips them.
- i_sym_valid outside RUN is ignored; nothing is consumed.
- o_sym_ready drops in the cycle after the FRAME_LEN-th accept, so no symbol FRAME_LEN+1 is ever taken in that frame.
- i_dec_ready while o_dec_valid=0 has no effect.
- Backpressure in OUT may last indefinitely; all outputs hold.
- i_select_node is not sampled outside the last SETTLE cycle.
- rst=0 in any state, including mid-TRACE or mid-OUT, aborts the frame. Partial survivors are discarded, and the next frame starts with CLR.

Reset values (rst=0 at a clock edge):
- State: CLR.
- o_sym_ready=0, o_bm_sym=00, o_en_add=0, o_acs_rst_n=0, o_dec_bits=0, o_dec_valid=0, o_busy=1.
- acc_cnt, cap_cnt, tb_state and all survivor entries: 0.

## Timing
- CLR takes 1 cycle. Therefore, after rst rises (or after an OUT transfer), o_sym_ready first goes high 1 cycle later.
- A symbol accepted at cycle k produces o_en_add=1 at k+1 and survivor capture at the edge ending k+2.
- With FRAME_LEN symbols accepted back-to-back from cycle k0, the last accept is at kL=k0+FRAME_LEN-1. Then:
  - i_select_node is sampled at kL+2+SETTLE.
  - TRACE spans kL+3+SETTLE through kL+2+SETTLE+FRAME_LEN.
  - o_dec_valid rises at kL+3+SETTLE+FRAME_LEN, which is kL+13 with the defaults.
- Throughput is one symbol per cycle in RUN. The per-frame overhead is 1 + 2 + SETTLE + FRAME_LEN cycles plus the OUT handshake.

## Test plan
- Reset and CLR:
  - Hold rst=0 for 3 cycles, then release. Every output must equal its reset value.
  - o_acs_rst_n=0 for exactly 1 cycle after release; o_sym_ready=1 on the following cycle.
- Back-to-back frame:
  - Stimulus: 8 symbols in 8 consecutive cycles with constant survivors (00→00, 10→00, 01→10, 11→11) and i_select_node=11.
  - Required: o_en_add high for 8 consecutive cycles; o_dec_valid at kL+13; o_dec_bits=8'hFF.
- Traceback path:
  - Stimulus: same survivors, i_select_node=01.
  - Required: path 01←10←00…, giving o_dec_bits=8'h40. With i_select_node=00, o_dec_bits=8'h00.
- Valid gaps:
  - Stimulus: symbols with i_sym_valid deasserted every other cycle.
  - Required: exactly 8 o_en_add pulses, each 1 cycle after its accept; cap_cnt reaches 8; decoded word identical to the back-to-back case.
- Output backpressure:
  - Stimulus: hold i_dec_ready=0 for 5 cycles in OUT, driving i_sym_valid=1 throughout.
  - Required: o_dec_valid and o_dec_bits stable, o_sym_ready=0. After the transfer, CLR follows, then a new frame decodes correctly.
- Mid-operation reset:
  - Stimulus: assert rst=0 during TRACE cycle 3.
  - Required: all outputs at reset values on the next edge. The following frame decodes correctly, with no stale survivor influence; check with a different survivor pattern.
